mult_result_acc: RTL and testbench

Downstream consumer of the 3-bit shift-add multiplier. Accepts each finished product `R` over a valid/ready handshake and accumulates a batch of `NPROD` products into a saturating sum. It presents each batch sum on a one-deep registered output with its own valid/ready handshake. A flush request emits a partial batch early.

---
 rtl/mult_result_acc.sv | 145 ++++++++++++++
 tb/tb_mult_result_acc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_acc.sv
// mult_result_acc: batches products from the shift-add multiplier into a
// saturating sum and presents each batch on a one-deep registered output slot.
module mult_result_acc #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned ACC_WIDTH = 8,
    parameter int unsigned NPROD     = 4,
    localparam int unsigned CW       = $clog2(NPROD) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   prod_valid,
    input  logic [2*WIDTH-1:0]     prod,
    output logic                   prod_ready,
    input  logic                   flush,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic [ACC_WIDTH-1:0]   sum,
    output logic [CW-1:0]          sum_cnt,
    output logic                   sum_sat
);

    localparam int unsigned AW1 = ACC_WIDTH + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc, acc_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   acc_sat, acc_sat_nxt;
    logic                   flush_pend, flush_pend_nxt;
    logic [ACC_WIDTH-1:0]   sum_nxt;
    logic [CW-1:0]          sum_cnt_nxt;
    logic                   sum_sat_nxt;
    logic                   sum_valid_nxt;

    logic                   slot_free;
    logic                   accept;
    logic [AW1-1:0]         add_full;
    logic                   add_sat;
    logic [CW-1:0]          cnt_inc;
    logic [ACC_WIDTH-1:0]   acc_upd;
    logic [CW-1:0]          cnt_upd;
    logic                   sat_upd;
    logic                   batch_full;
    logic                   flush_req;
    logic                   has_prod;
    logic                   load;

    // Slot can take a new batch when empty or being drained this cycle.
    assign slot_free = !sum_valid || sum_ready;

    // Hold off the batch-completing product while the slot is blocked, and all
    // products while a partial batch waits to be flushed.
    assign prod_ready = (state == ACCUM) &&
                        !((cnt == CW'(NPROD - 1)) && !slot_free);

    assign accept = prod_valid && prod_ready;

    // Next-state, accumulation and output-slot logic.
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        acc_sat_nxt    = acc_sat;
        flush_pend_nxt = flush_pend;
        sum_nxt        = sum;
        sum_cnt_nxt    = sum_cnt;
        sum_sat_nxt    = sum_sat;
        sum_valid_nxt  = sum_valid;

        add_full = {1'b0, acc} + AW1'(prod);
        add_sat  = add_full[ACC_WIDTH] || acc_sat;
        cnt_inc  = cnt + CW'(1);

        // Accumulator contents after this cycle's accept, before any close.
        acc_upd = acc;
        cnt_upd = cnt;
        sat_upd = acc_sat;
        if (accept) begin
            acc_upd = add_sat ? {ACC_WIDTH{1'b1}} : add_full[ACC_WIDTH-1:0];
            cnt_upd = cnt_inc;
            sat_upd = add_sat;
        end

        batch_full = accept && (cnt_inc == CW'(NPROD));
        flush_req  = flush || flush_pend;
        has_prod   = (cnt_upd != '0);
        load       = slot_free && (batch_full || (flush_req && has_prod));

        // Drain first; a same-edge load overrides it below.
        if (sum_valid && sum_ready) begin
            sum_valid_nxt = 1'b0;
        end

        if (load) begin
            sum_nxt        = acc_upd;
            sum_cnt_nxt    = cnt_upd;
            sum_sat_nxt    = sat_upd;
            sum_valid_nxt  = 1'b1;
            acc_nxt        = '0;
            cnt_nxt        = '0;
            acc_sat_nxt    = 1'b0;
            flush_pend_nxt = 1'b0;
        end else begin
            acc_nxt     = acc_upd;
            cnt_nxt     = cnt_upd;
            acc_sat_nxt = sat_upd;
            // Partial batch must wait for the slot to free up.
            if (flush_req && has_prod) begin
                flush_pend_nxt = 1'b1;
            end
        end

        state_nxt = flush_pend_nxt ? STALL : ACCUM;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            acc_sat    <= 1'b0;
            flush_pend <= 1'b0;
            sum        <= '0;
            sum_cnt    <= '0;
            sum_sat    <= 1'b0;
            sum_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            acc_sat    <= acc_sat_nxt;
            flush_pend <= flush_pend_nxt;
            sum        <= sum_nxt;
            sum_cnt    <= sum_cnt_nxt;
            sum_sat    <= sum_sat_nxt;
            sum_valid  <= sum_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mult_result_acc.sv
// Scoreboard bench for mult_result_acc: an 8-bit and a 7-bit accumulator instance.
module tb_mult_result_acc;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;

    // 8-bit accumulator instance
    logic       prod_valid, prod_ready, sum_valid, sum_ready, sum_sat;
    logic [5:0] prod;
    logic [7:0] sum;
    logic [2:0] sum_cnt;

    // 7-bit accumulator instance
    logic       prod_valid7, prod_ready7, sum_valid7, sum_ready7, sum_sat7, flush7;
    logic [5:0] prod7;
    logic [6:0] sum7;
    logic [2:0] sum_cnt7;

    int checks   = 0;
    int failures = 0;

    // Expected batch: {sum[7:0], cnt[2:0], sat}
    logic [11:0] exp_q[$];
    logic [11:0] exp_q7[$];

    mult_result_acc #(.WIDTH(3), .ACC_WIDTH(8), .NPROD(4)) dut (
        .clk(clk), .reset(reset),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
        .flush(flush),
        .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum(sum), .sum_cnt(sum_cnt), .sum_sat(sum_sat)
    );

    mult_result_acc #(.WIDTH(3), .ACC_WIDTH(7), .NPROD(4)) dut7 (
        .clk(clk), .reset(reset),
        .prod_valid(prod_valid7), .prod(prod7), .prod_ready(prod_ready7),
        .flush(flush7),
        .sum_valid(sum_valid7), .sum_ready(sum_ready7),
        .sum(sum7), .sum_cnt(sum_cnt7), .sum_sat(sum_sat7)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one product and return one step after the accepting edge.
    task automatic send(input bit use7, input logic [5:0] p);
        int waited = 0;
        if (use7) begin prod_valid7 = 1'b1; prod7 = p; end
        else      begin prod_valid  = 1'b1; prod  = p; end
        @(negedge clk);
        while (!(use7 ? prod_ready7 : prod_ready) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) check("send_timeout", 32'(waited), 0);
        @(posedge clk); #1;
        prod_valid  = 1'b0;
        prod_valid7 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare each transferred batch against the scoreboard.
    always @(negedge clk) begin
        if (!reset && sum_valid && sum_ready) begin
            if (exp_q.size() == 0) check("unexpected_sum", {20'd0, sum, sum_cnt, sum_sat}, 0);
            else check("batch", {20'd0, sum, sum_cnt, sum_sat}, {20'd0, exp_q.pop_front()});
        end
        if (!reset && sum_valid7 && sum_ready7) begin
            if (exp_q7.size() == 0) check("unexpected_sum7", {20'd0, 1'b0, sum7, sum_cnt7, sum_sat7}, 0);
            else check("batch7", {20'd0, 1'b0, sum7, sum_cnt7, sum_sat7}, {20'd0, exp_q7.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; flush7 = 1'b0;
        prod_valid = 1'b0; prod = '0; sum_ready = 1'b1;
        prod_valid7 = 1'b0; prod7 = '0; sum_ready7 = 1'b1;
        idle(2);
        check("rst_sum_valid", 32'(sum_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_sum_cnt", 32'(sum_cnt), 0);
        check("rst_sum_sat", 32'(sum_sat), 0);
        check("rst_prod_ready", 32'(prod_ready), 1);
        @(negedge clk); reset = 1'b0;
        idle(1);

        // Full batch of 49s, one cycle latency
        exp_q.push_back({8'd196, 3'd4, 1'b0});
        repeat (4) send(1'b0, 6'd49);
        check("latency_valid", 32'(sum_valid), 1);
        idle(3);

        // Saturation on 7-bit accumulator, flushed partial batch
        exp_q7.push_back({8'd127, 3'd3, 1'b1});
        exp_q7.push_back({8'd10, 3'd4, 1'b0});
        repeat (3) send(1'b1, 6'd49);
        flush7 = 1'b1;
        idle(1);
        flush7 = 1'b0;
        check("sat_flush_valid", 32'(sum_valid7), 1);
        send(1'b1, 6'd1); send(1'b1, 6'd2); send(1'b1, 6'd3); send(1'b1, 6'd4);
        idle(3);

        // Back-pressure: held slot blocks the batch-completing product
        exp_q.push_back({8'd26, 3'd4, 1'b0});
        exp_q.push_back({8'd10, 3'd4, 1'b0});
        exp_q.push_back({8'd46, 3'd4, 1'b0});
        sum_ready = 1'b0;
        send(1'b0, 6'd5); send(1'b0, 6'd6); send(1'b0, 6'd7); send(1'b0, 6'd8);
        send(1'b0, 6'd1); send(1'b0, 6'd2); send(1'b0, 6'd3);
        prod_valid = 1'b1; prod = 6'd4;
        @(negedge clk);
        check("bp_ready_low_a", 32'(prod_ready), 0);
        @(negedge clk);
        check("bp_ready_low_b", 32'(prod_ready), 0);
        check("bp_hold_sum", 32'(sum), 26);
        check("bp_hold_valid", 32'(sum_valid), 1);
        @(posedge clk); #1;
        sum_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_high", 32'(prod_ready), 1);
        @(posedge clk); #1;
        prod_valid = 1'b0;
        check("bp_reload_valid", 32'(sum_valid), 1);
        send(1'b0, 6'd10); send(1'b0, 6'd11); send(1'b0, 6'd12); send(1'b0, 6'd13);
        idle(3);

        // Flush while the slot is held becomes pending
        exp_q.push_back({8'd80, 3'd4, 1'b0});
        exp_q.push_back({8'd7, 3'd2, 1'b0});
        sum_ready = 1'b0;
        repeat (4) send(1'b0, 6'd20);
        send(1'b0, 6'd3); send(1'b0, 6'd4);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        @(negedge clk);
        check("pend_ready_low", 32'(prod_ready), 0);
        check("pend_hold_sum", 32'(sum), 80);
        @(posedge clk); #1;
        sum_ready = 1'b1;
        idle(1);
        check("pend_load_cnt", 32'(sum_cnt), 2);
        check("pend_ready_back", 32'(prod_ready), 1);
        idle(3);

        // Flush with empty accumulator is ignored; flush with first accept closes
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("empty_flush_a", 32'(sum_valid), 0);
        idle(1);
        check("empty_flush_b", 32'(sum_valid), 0);
        exp_q.push_back({8'd9, 3'd1, 1'b0});
        flush = 1'b1; prod_valid = 1'b1; prod = 6'd9;
        idle(1);
        flush = 1'b0; prod_valid = 1'b0;
        check("coinc_flush_valid", 32'(sum_valid), 1);
        idle(3);

        // Asynchronous reset mid-batch and with a held output
        send(1'b0, 6'd1); send(1'b0, 6'd2);
        #3 reset = 1'b1;
        #1;
        check("arst_mid_valid", 32'(sum_valid), 0);
        check("arst_mid_ready", 32'(prod_ready), 1);
        @(negedge clk); reset = 1'b0;
        sum_ready = 1'b0;
        repeat (4) send(1'b0, 6'd5);
        check("held_before_rst", 32'(sum_valid), 1);
        #3 reset = 1'b1;
        #1;
        check("arst_held_valid", 32'(sum_valid), 0);
        check("arst_held_sum", 32'(sum), 0);
        check("arst_held_cnt", 32'(sum_cnt), 0);
        @(negedge clk); reset = 1'b0;
        sum_ready = 1'b1;
        exp_q.push_back({8'd4, 3'd4, 1'b0});
        repeat (4) send(1'b0, 6'd1);
        idle(4);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        check("scoreboard7_empty", 32'(exp_q7.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
